// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: occupancy encoding, the
// "no destination" register index and the default widths of the core's stages.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

  localparam int unsigned RD_ZERO     = 0;
  localparam int unsigned PIPE_DATA_W = 32;
  localparam int unsigned PIPE_RD_W   = 5;

  function automatic logic occ_valid(occ_e s);
    return s != ST_EMPTY;
  endfunction

  // Room exists for one more entry unless both slots are full.
  function automatic logic occ_has_room(occ_e s);
    return s != ST_TWO;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One enable-loaded holding register for {data, rd, regwrite}. Reset and clear
// both empty it; clear wins over load so a flushed accept is discarded.
module pipe_slot import pipe_pkg::*; #(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned RD_W   = PIPE_RD_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic              regwrite_i,
  output logic [DATA_W-1:0] data_o,
  output logic [RD_W-1:0]   rd_o,
  output logic              regwrite_o
);

  logic [DATA_W-1:0] data_q;
  logic [RD_W-1:0]   rd_q;
  logic              regwrite_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q     <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
    end else if (clr_i) begin
      data_q     <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
    end else if (load_i) begin
      data_q     <= data_i;
      rd_q       <= rd_i;
      regwrite_q <= regwrite_i;
    end
  end

  assign data_o     = data_q;
  assign rd_o       = rd_q;
  assign regwrite_o = regwrite_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and an
// optional two-entry skid buffer that breaks the out_ready -> in_ready path.
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned RD_W   = PIPE_RD_W,
  parameter bit          SKID   = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [RD_W-1:0]   in_rd_i,
  input  logic              in_regwrite_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [RD_W-1:0]   out_rd_o,
  output logic              out_regwrite_o
);

  occ_e state_q, state_d;

  logic accept, retire, out_valid;
  logic main_load, main_from_skid, skid_load;

  logic [DATA_W-1:0] main_data_in, main_data, skid_data;
  logic [RD_W-1:0]   main_rd_in, main_rd, skid_rd;
  logic              main_rw_in, main_rw, skid_rw;

  assign out_valid = occ_valid(state_q);
  assign accept    = in_valid_i && in_ready_o;
  assign retire    = out_valid && out_ready_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) state_d = ST_ONE;
        end
        ST_ONE: begin
          if (accept && !retire) begin
            state_d = ST_TWO;
          end else if (!accept && retire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (retire) state_d = ST_ONE;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Slot control: the skid slot only fills when an accept meets a stalled output.
  always_comb begin
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        main_load = accept;
      end
      ST_ONE: begin
        main_load = accept && retire;
        skid_load = accept && !retire;
      end
      ST_TWO: begin
        main_load      = retire;
        main_from_skid = 1'b1;
      end
      default: ;
    endcase
  end

  assign main_data_in = main_from_skid ? skid_data : in_data_i;
  assign main_rd_in   = main_from_skid ? skid_rd   : in_rd_i;
  assign main_rw_in   = main_from_skid ? skid_rw   : in_regwrite_i;

  pipe_slot #(
    .DATA_W (DATA_W),
    .RD_W   (RD_W)
  ) u_main (
    .clk_i      (clk_i),
    .rst_ni     (reset_ni),
    .clr_i      (flush_i),
    .load_i     (main_load),
    .data_i     (main_data_in),
    .rd_i       (main_rd_in),
    .regwrite_i (main_rw_in),
    .data_o     (main_data),
    .rd_o       (main_rd),
    .regwrite_o (main_rw)
  );

  if (SKID) begin : g_skid
    logic in_ready_q;

    always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
        in_ready_q <= 1'b0;
      end else begin
        in_ready_q <= occ_has_room(state_d);
      end
    end

    assign in_ready_o = in_ready_q;

    pipe_slot #(
      .DATA_W (DATA_W),
      .RD_W   (RD_W)
    ) u_skid (
      .clk_i      (clk_i),
      .rst_ni     (reset_ni),
      .clr_i      (flush_i),
      .load_i     (skid_load),
      .data_i     (in_data_i),
      .rd_i       (in_rd_i),
      .regwrite_i (in_regwrite_i),
      .data_o     (skid_data),
      .rd_o       (skid_rd),
      .regwrite_o (skid_rw)
    );
  end else begin : g_single
    // Single slot: ready whenever the held entry leaves this cycle or none is held.
    logic unused_skid;

    assign in_ready_o  = out_ready_i || !out_valid;
    assign skid_data   = in_data_i;
    assign skid_rd     = in_rd_i;
    assign skid_rw     = in_regwrite_i;
    assign unused_skid = skid_load;
  end

  assign out_valid_o    = out_valid;
  assign out_data_o     = main_data;
  assign out_rd_o       = out_valid ? main_rd : RD_W'(RD_ZERO);
  assign out_regwrite_o = out_valid && main_rw;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid build (streaming, stall, flush, reset)
// and the single-slot build (combinational ready, hold, pass-through).
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst_n;
  logic        flush;

  logic        in_valid, in_ready, in_rw, out_valid, out_ready, out_rw;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_rd, out_rd;

  logic        z_in_valid, z_in_ready, z_in_rw, z_out_valid, z_out_ready, z_out_rw;
  logic [31:0] z_in_data, z_out_data;
  logic [4:0]  z_in_rd, z_out_rd;

  int vectors;
  int miscompares;

  pipe_stage_reg #(
    .DATA_W (32),
    .RD_W   (5),
    .SKID   (1'b1)
  ) dut (
    .clk_i          (clk),
    .reset_ni       (rst_n),
    .flush_i        (flush),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .in_rd_i        (in_rd),
    .in_regwrite_i  (in_rw),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data),
    .out_rd_o       (out_rd),
    .out_regwrite_o (out_rw)
  );

  pipe_stage_reg #(
    .DATA_W (32),
    .RD_W   (5),
    .SKID   (1'b0)
  ) dut0 (
    .clk_i          (clk),
    .reset_ni       (rst_n),
    .flush_i        (flush),
    .in_valid_i     (z_in_valid),
    .in_ready_o     (z_in_ready),
    .in_data_i      (z_in_data),
    .in_rd_i        (z_in_rd),
    .in_regwrite_i  (z_in_rw),
    .out_valid_o    (z_out_valid),
    .out_ready_i    (z_out_ready),
    .out_data_o     (z_out_data),
    .out_rd_o       (z_out_rd),
    .out_regwrite_o (z_out_rw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_rd       = '0;
    in_rw       = 1'b0;
    out_ready   = 1'b0;
    z_in_valid  = 1'b0;
    z_in_data   = '0;
    z_in_rd     = '0;
    z_in_rw     = 1'b0;
    z_out_ready = 1'b1;

    // Reset: two cycles low, everything zero.
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_out_rw", 32'(out_rw), 32'd0);
    tick();
    chk("rst2_out_valid", 32'(out_valid), 32'd0);

    // Streaming 1..8
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_rw     = 1'b1;
    in_data   = 32'd1;
    in_rd     = 5'd1;
    tick();
    chk("first_edge_in_ready", 32'(in_ready), 32'd1);
    chk("first_edge_out_valid", 32'(out_valid), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_data", out_data, 32'(i));
      chk("stream_rd", 32'(out_rd), 32'(i));
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      in_data = 32'(i + 1);
      in_rd   = 5'(i + 1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_rd", 32'(out_rd), 32'd0);
    chk("drain_rw", 32'(out_rw), 32'd0);

    // Stall with skid: A held, B in skid, C waits.
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = 32'hA;
    in_rd     = 5'd10;
    tick();
    chk("stall_a_data", out_data, 32'hA);
    chk("stall_a_in_ready", 32'(in_ready), 32'd1);
    in_data = 32'hB;
    in_rd   = 5'd11;
    tick();
    chk("stall_b_hold_a", out_data, 32'hA);
    chk("stall_two_in_ready", 32'(in_ready), 32'd0);
    in_data = 32'hC;
    in_rd   = 5'd12;
    tick();
    chk("stall_hold_a", out_data, 32'hA);
    chk("stall_hold_rd", 32'(out_rd), 32'd10);
    chk("stall_two_in_ready2", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("release_b", out_data, 32'hB);
    chk("release_b_rd", 32'(out_rd), 32'd11);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("release_c", out_data, 32'hC);
    in_valid = 1'b0;
    tick();
    chk("release_empty", 32'(out_valid), 32'd0);

    // Flush while in TWO with an incoming 0xD.
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = 32'h11;
    tick();
    in_data = 32'h12;
    tick();
    chk("flush_pre_two", 32'(in_ready), 32'd0);
    flush   = 1'b1;
    in_data = 32'hD;
    tick();
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_rd", 32'(out_rd), 32'd0);
    chk("flush_rw", 32'(out_rw), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("flush_no_d", 32'(out_valid), 32'd0);

    // Flush together with a retire: entry seen once, then empty.
    in_valid = 1'b1;
    in_data  = 32'h21;
    in_rd    = 5'd3;
    tick();
    chk("fr_present", out_data, 32'h21);
    chk("fr_present_valid", 32'(out_valid & out_ready), 32'd1);
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    chk("fr_empty", 32'(out_valid), 32'd0);
    flush = 1'b0;
    tick();
    chk("fr_still_empty", 32'(out_valid), 32'd0);

    // Reset during a stall with flush high.
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_data   = 32'h31;
    tick();
    in_data = 32'h32;
    tick();
    chk("rs_pre_two", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    flush = 1'b1;
    tick();
    chk("rs_in_ready", 32'(in_ready), 32'd0);
    chk("rs_valid", 32'(out_valid), 32'd0);
    chk("rs_data", out_data, 32'd0);
    chk("rs_rd", 32'(out_rd), 32'd0);
    chk("rs_rw", 32'(out_rw), 32'd0);
    rst_n     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    in_data   = 32'h41;
    tick();
    chk("rs_first_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("rs_resume_data", out_data, 32'h41);
    chk("rs_resume_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();

    // Single-slot build.
    z_in_valid  = 1'b1;
    z_in_data   = 32'h51;
    z_in_rd     = 5'd7;
    z_in_rw     = 1'b1;
    z_out_ready = 1'b0;
    #1;
    chk("z_empty_ready", 32'(z_in_ready), 32'd1);
    tick();
    chk("z_valid", 32'(z_out_valid), 32'd1);
    chk("z_data", z_out_data, 32'h51);
    chk("z_rd", 32'(z_out_rd), 32'd7);
    z_in_data = 32'h52;
    z_in_rd   = 5'd2;
    #1;
    chk("z_comb_not_ready", 32'(z_in_ready), 32'd0);
    z_out_ready = 1'b1;
    #1;
    chk("z_comb_ready", 32'(z_in_ready), 32'd1);
    z_out_ready = 1'b0;
    tick();
    chk("z_hold_data", z_out_data, 32'h51);
    chk("z_hold_rd", 32'(z_out_rd), 32'd7);
    chk("z_hold_rw", 32'(z_out_rw), 32'd1);
    z_out_ready = 1'b1;
    z_in_data   = 32'h53;
    z_in_rd     = 5'd7;
    tick();
    chk("z_pass_data", z_out_data, 32'h53);
    chk("z_pass_rd", 32'(z_out_rd), 32'd7);
    z_in_valid = 1'b0;
    tick();
    chk("z_empty_valid", 32'(z_out_valid), 32'd0);
    chk("z_empty_rd", 32'(z_out_rd), 32'd0);
    chk("z_empty_rw", 32'(z_out_rw), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It generalises the fixed MEM/WB-style stage registers of the pipelined RISC-V core:

- The payload width and destination-register width are set by parameters.
- Back-pressure from the next stage stalls the stage without losing data.
- A flush removes in-flight instructions for branch and jump recovery.

One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface

Parameters:
- DATA_W, 32: width of the opaque payload bundle (ALU result, read data, PC+4, control, ...).
- RD_W, 5: width of the destination register index.
- SKID, 1: 1 selects the two-entry skid buffer with registered in_ready; 0 selects a single register with combinational in_ready.

Ports:
- clk  in  1  stage clock, rising edge.
- reset  in  1  synchronous, active-low reset; sampled only on the rising edge of clk.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- in_rd  in  RD_W  upstream destination register.
- in_regwrite  in  1  upstream writes rd.
- out_valid  out  1  stage holds a valid instruction.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  held payload.
- out_rd  out  RD_W  held destination register.
- out_regwrite  out  1  held write enable, gated by out_valid.

## Operation

- Handshake rules:
  - An accept occurs on a rising edge where in_valid && in_ready.
  - A retire occurs on a rising edge where out_valid && out_ready.
  - Order is preserved; nothing is duplicated or dropped except by flush.
- Occupancy states (SKID=1): EMPTY, ONE (main slot full), TWO (main and skid slots full).
  - EMPTY: accept -> ONE.
  - ONE: accept with no retire -> TWO. Accept with retire, or neither -> stay in ONE. Retire only -> EMPTY.
  - TWO: in_ready=0, so no accept is possible. Retire -> ONE; the skid entry moves to the main slot.
- in_ready (SKID=1) is a registered signal, equal to (state != TWO).
- In TWO, the main slot drives out_*. The skid slot holds the entry that arrived while out_ready was low.
- SKID=0: one slot only, with in_ready = out_ready || !out_valid, computed combinationally.
- While out_valid && !out_ready, out_data, out_rd and out_regwrite stay stable.
- When out_valid=0:
  - out_regwrite=0 and out_rd=0, so the hazard and forwarding logic sees no write.
  - out_data holds its last value; its content is don't-care.
- Flush:
  - On the next edge, the stage goes to EMPTY with out_valid=0, out_rd=0 and out_regwrite=0.
  - An accept in the same cycle is discarded.
  - A simultaneous retire still completes downstream.
- Reset (low at an edge):
  - Forces EMPTY, with every output at 0, including out_data and in_ready.
  - Reset takes priority over flush and over the handshakes.
  - After reset deasserts, in_ready=1 from the first edge.

## Timing

- Latency: an entry accepted at edge N is visible on out_* after edge N, i.e. in cycle N+1.
- Throughput is 1 per cycle while out_ready=1.
- SKID=1: no combinational path from out_ready to in_ready. Worst case, one cycle of in_ready=0 follows a single-cycle stall.
- SKID=0: combinational path out_ready -> in_ready; out_* are still registered.
- Reset, flush and all state updates occur on the rising edge of clk only.

## Structure

- Shared package (pipe_pkg) holds:
  - the occupancy state encoding (ST_EMPTY, ST_ONE, ST_TWO);
  - the RD_ZERO constant;
  - the default widths used by the core's stage instances.
- One sub-module: pipe_slot. It is a single enable-loaded register of {data, rd, regwrite} with synchronous clear.
  - SKID=1 instantiates it twice (main and skid).
  - SKID=0 instantiates it once.
- Occupancy control lives in pipe_stage_reg.

## Test plan

- Streaming:
  - Stimulus: reset low for 2 cycles, then in_valid=1, out_ready=1 with in_data=1..8.
  - Required: all outputs 0 during reset; out_data=1..8 on consecutive cycles, each 1 cycle after its accept; in_ready stays 1.
- Stall, SKID=1:
  - Stimulus: drop out_ready for 3 cycles while feeding 0xA, 0xB, 0xC.
  - Required: 0xA held stable on out_data; 0xB captured in the skid slot; in_ready=0 while in TWO; 0xC accepted only after out_ready returns; output order A, B, C.
- Flush:
  - Stimulus: assert flush in TWO, with in_valid=1 and in_data=0xD.
  - Required: next cycle out_valid=0, out_rd=0, out_regwrite=0; 0xD not emitted; in_ready=1.
- Flush with retire:
  - Stimulus: flush and a retire in the same cycle.
  - Required: retiring entry observed once downstream; stage empty afterwards.
- Reset mid-stall:
  - Stimulus: reset low while in TWO with flush=1.
  - Required: EMPTY; all outputs 0; resumes accepting on the first edge after reset returns high.
- SKID=0 build:
  - Stimulus: out_ready=0 with out_valid=1.
  - Required: in_ready=0 in the same cycle (combinational); data held; rd=5'd7 passes through unchanged after release.
